// File: rtl/instr_fetch_ctrl.sv
// Sequential instruction fetch controller: drives the memory address, registers returned words, handles stall/redirect/halt.
// One cycle from MEM_ADDR to INSTR; STALL freezes outputs and PC, a redirect overrides STALL and flushes VALID.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 262144,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        STALL,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  output logic [31:0] MEM_ADDR,
  input  logic [31:0] MEM_DATA,
  output logic [31:0] INSTR,
  output logic [31:0] PC_OUT,
  output logic        VALID,
  output logic [1:0]  STATE,
  output logic        ALIGN_ERR,
  output logic [31:0] FETCH_CNT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        align_q, align_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] tgt_pc;

  // Redirect target is word-aligned by dropping the low bits, then folded into memory range.
  assign tgt_pc = {BR_TARGET[31:2], 2'b00} & ADDR_MASK;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    align_d  = align_q;
    cnt_d    = cnt_q;

    if (BR_TAKEN && (BR_TARGET[1:0] != 2'b00)) begin
      align_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (BR_TAKEN) pc_d = tgt_pc;
        if (EN) state_d = S_RUN;
      end
      S_RUN: begin
        if (!EN) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          if (BR_TAKEN) pc_d = tgt_pc;
        end else if (BR_TAKEN) begin
          pc_d    = tgt_pc;
          valid_d = 1'b0;
        end else if (!STALL) begin
          instr_d  = MEM_DATA;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = (pc_q + 32'd4) & ADDR_MASK;
          cnt_d    = cnt_q + 32'd1;
          if (MEM_DATA == HALT_WORD) state_d = S_HALT;
        end
      end
      S_HALT: begin
        // The halt word stays visible until downstream accepts it; only a redirect restarts fetch.
        if (BR_TAKEN) begin
          pc_d    = tgt_pc;
          valid_d = 1'b0;
          state_d = S_RUN;
        end else if (!STALL) begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC & ADDR_MASK;
      instr_q  <= 32'd0;
      pc_out_q <= 32'd0;
      valid_q  <= 1'b0;
      align_q  <= 1'b0;
      cnt_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      align_q  <= align_d;
      cnt_q    <= cnt_d;
    end
  end

  assign MEM_ADDR  = pc_q;
  assign INSTR     = instr_q;
  assign PC_OUT    = pc_out_q;
  assign VALID     = valid_q;
  assign STATE     = state_q;
  assign ALIGN_ERR = align_q;
  assign FETCH_CNT = cnt_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed table-driven bench for instr_fetch_ctrl with a combinational instruction memory model.
module tb_instr_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic        STALL;
  logic        BR_TAKEN;
  logic [31:0] BR_TARGET;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_DATA;
  logic [31:0] INSTR;
  logic [31:0] PC_OUT;
  logic        VALID;
  logic [1:0]  STATE;
  logic        ALIGN_ERR;
  logic [31:0] FETCH_CNT;

  logic [31:0] mem [0:65535];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  assign MEM_DATA = mem[MEM_ADDR[17:2]];

  instr_fetch_ctrl dut (
    .CLK(CLK), .RST(RST), .EN(EN), .STALL(STALL), .BR_TAKEN(BR_TAKEN),
    .BR_TARGET(BR_TARGET), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .INSTR(INSTR), .PC_OUT(PC_OUT), .VALID(VALID), .STATE(STATE),
    .ALIGN_ERR(ALIGN_ERR), .FETCH_CNT(FETCH_CNT)
  );

  typedef struct {
    logic        en, stall, br;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] ei, epc, eaddr;
    logic [1:0]  est;
    logic        ea;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vt [24];

  function automatic vec_t mk(logic en, logic stall, logic br, logic [31:0] tgt,
                              logic ev, logic [31:0] ei, logic [31:0] epc, logic [31:0] eaddr,
                              logic [1:0] est, logic ea, logic [31:0] ecnt);
    vec_t v;
    v.en = en; v.stall = stall; v.br = br; v.tgt = tgt;
    v.ev = ev; v.ei = ei; v.epc = epc; v.eaddr = eaddr;
    v.est = est; v.ea = ea; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " MEM_ADDR"},  MEM_ADDR, 32'h0);
    chk({tag, " INSTR"},     INSTR, 32'h0);
    chk({tag, " PC_OUT"},    PC_OUT, 32'h0);
    chk({tag, " VALID"},     32'(VALID), 32'h0);
    chk({tag, " STATE"},     32'(STATE), 32'h0);
    chk({tag, " ALIGN_ERR"}, 32'(ALIGN_ERR), 32'h0);
    chk({tag, " FETCH_CNT"}, FETCH_CNT, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    mem[0]      = 32'h0000_00FF;
    mem[1]      = 32'h0000_FF00;
    mem[2]      = 32'h00FF_0000;
    mem[3]      = 32'hFF00_0000;
    mem[4]      = 32'hFFFF_FFFF;
    mem[8]      = 32'h3333_3333;
    mem[16'h40] = 32'h1111_1111;
    mem[16'hFFFF] = 32'h2222_2222;

    //            en st br tgt           v  instr          pc_out      addr         st a  cnt
    vt[0]  = mk(1, 0, 0, 32'h0,       0, 32'h0,        32'h0,      32'h0,       1, 0, 0);
    vt[1]  = mk(1, 0, 0, 32'h0,       1, 32'h000000FF, 32'h0,      32'h4,       1, 0, 1);
    vt[2]  = mk(1, 0, 0, 32'h0,       1, 32'h0000FF00, 32'h4,      32'h8,       1, 0, 2);
    vt[3]  = mk(1, 1, 0, 32'h0,       1, 32'h0000FF00, 32'h4,      32'h8,       1, 0, 2);
    vt[4]  = mk(1, 1, 0, 32'h0,       1, 32'h0000FF00, 32'h4,      32'h8,       1, 0, 2);
    vt[5]  = mk(1, 1, 0, 32'h0,       1, 32'h0000FF00, 32'h4,      32'h8,       1, 0, 2);
    vt[6]  = mk(1, 0, 0, 32'h0,       1, 32'h00FF0000, 32'h8,      32'hC,       1, 0, 3);
    vt[7]  = mk(1, 0, 0, 32'h0,       1, 32'hFF000000, 32'hC,      32'h10,      1, 0, 4);
    vt[8]  = mk(1, 1, 1, 32'h102,     0, 32'h0,        32'h0,      32'h100,     1, 1, 4);
    vt[9]  = mk(1, 0, 0, 32'h0,       1, 32'h11111111, 32'h100,    32'h104,     1, 1, 5);
    vt[10] = mk(1, 0, 1, 32'h3FFFC,   0, 32'h0,        32'h0,      32'h3FFFC,   1, 1, 5);
    vt[11] = mk(1, 0, 0, 32'h0,       1, 32'h22222222, 32'h3FFFC,  32'h0,       1, 1, 6);
    vt[12] = mk(1, 0, 0, 32'h0,       1, 32'h000000FF, 32'h0,      32'h4,       1, 1, 7);
    vt[13] = mk(1, 0, 1, 32'h10,      0, 32'h0,        32'h0,      32'h10,      1, 1, 7);
    vt[14] = mk(1, 0, 0, 32'h0,       1, 32'hFFFFFFFF, 32'h10,     32'h14,      2, 1, 8);
    vt[15] = mk(1, 1, 0, 32'h0,       1, 32'hFFFFFFFF, 32'h10,     32'h14,      2, 1, 8);
    vt[16] = mk(0, 0, 0, 32'h0,       0, 32'h0,        32'h0,      32'h14,      2, 1, 8);
    vt[17] = mk(1, 0, 0, 32'h0,       0, 32'h0,        32'h0,      32'h14,      2, 1, 8);
    vt[18] = mk(0, 0, 0, 32'h0,       0, 32'h0,        32'h0,      32'h14,      2, 1, 8);
    vt[19] = mk(1, 0, 1, 32'h0,       0, 32'h0,        32'h0,      32'h0,       1, 1, 8);
    vt[20] = mk(1, 0, 0, 32'h0,       1, 32'h000000FF, 32'h0,      32'h4,       1, 1, 9);
    vt[21] = mk(0, 0, 1, 32'h20,      0, 32'h0,        32'h0,      32'h20,      0, 1, 9);
    vt[22] = mk(1, 0, 0, 32'h0,       0, 32'h0,        32'h0,      32'h20,      1, 1, 9);
    vt[23] = mk(1, 0, 0, 32'h0,       1, 32'h33333333, 32'h20,     32'h24,      1, 1, 10);

    RST = 1'b1; EN = 1'b0; STALL = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = 32'h0;
    #12;
    chk_reset_vals("reset");
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 24; i++) begin
      EN = vt[i].en; STALL = vt[i].stall; BR_TAKEN = vt[i].br; BR_TARGET = vt[i].tgt;
      step();
      chk($sformatf("v%0d VALID", i), 32'(VALID), 32'(vt[i].ev));
      if (vt[i].ev) begin
        chk($sformatf("v%0d INSTR", i), INSTR, vt[i].ei);
        chk($sformatf("v%0d PC_OUT", i), PC_OUT, vt[i].epc);
      end
      chk($sformatf("v%0d MEM_ADDR", i), MEM_ADDR, vt[i].eaddr);
      chk($sformatf("v%0d STATE", i), 32'(STATE), 32'(vt[i].est));
      chk($sformatf("v%0d ALIGN_ERR", i), 32'(ALIGN_ERR), 32'(vt[i].ea));
      chk($sformatf("v%0d FETCH_CNT", i), FETCH_CNT, vt[i].ecnt);
    end

    // Asynchronous reset between edges while stalled in RUN.
    EN = 1'b1; STALL = 1'b1; BR_TAKEN = 1'b0;
    step();
    chk("pre-rst VALID", 32'(VALID), 32'h1);
    #2;
    RST = 1'b1;
    #1;
    chk_reset_vals("async rst");
    step();
    chk_reset_vals("held rst");
    RST = 1'b0; STALL = 1'b0; EN = 1'b1;
    step();
    chk("post-rst STATE", 32'(STATE), 32'h1);
    chk("post-rst VALID", 32'(VALID), 32'h0);
    chk("post-rst MEM_ADDR", MEM_ADDR, 32'h0);
    step();
    chk("post-rst first VALID", 32'(VALID), 32'h1);
    chk("post-rst first INSTR", INSTR, 32'h0000_00FF);
    chk("post-rst first PC_OUT", PC_OUT, 32'h0);
    chk("post-rst FETCH_CNT", FETCH_CNT, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
